// File: rtl/scoreboard_hazard_unit.sv
// Decode-side hazard unit: a per-register scoreboard tracks pending writers and a
// reservation wheel tracks the single register-file write port for fixed-latency producers.
module scoreboard_hazard_unit #(
    parameter int REGISTER_WIDTH = 5,
    parameter int MAX_LAT        = 8,
    parameter int LAT_W          = $clog2(MAX_LAT + 1),
    parameter int FWD_EN         = 1,
    localparam int NUM_REGS      = 2 ** REGISTER_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      dec_valid_i,
    input  logic                      dec_rs1_needed_i,
    input  logic [REGISTER_WIDTH-1:0] dec_rs1_i,
    input  logic                      dec_rs2_needed_i,
    input  logic [REGISTER_WIDTH-1:0] dec_rs2_i,
    input  logic                      dec_rd_wr_en_i,
    input  logic [REGISTER_WIDTH-1:0] dec_rd_i,
    input  logic [LAT_W-1:0]          dec_latency_i,
    input  logic                      rob_is_full_i,
    input  logic                      ex_backpressure_i,
    input  logic                      flush_i,
    input  logic                      var_wb_req_i,
    input  logic [REGISTER_WIDTH-1:0] var_wb_reg_i,
    output logic                      issue_o,
    output logic                      stall_decode_o,
    output logic                      stall_fetch_o,
    output logic                      raw_stall_o,
    output logic                      waw_stall_o,
    output logic                      wb_conflict_o,
    output logic                      var_wb_stall_o,
    output logic [NUM_REGS-1:0]       busy_regs_o
);

    localparam bit FwdEn = (FWD_EN != 0);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] var_q, var_d;
    logic [LAT_W-1:0]    rem_q [NUM_REGS];
    logic [LAT_W-1:0]    rem_d [NUM_REGS];
    logic [MAX_LAT:0]    wheel_q, wheel_d;
    logic [MAX_LAT:0]    lat_hit;

    logic raw1, raw2, raw_any, waw, wb_conflict, stall, issue;
    logic alloc, alloc_fixed, alloc_var, var_wb_deny, var_wb_grant;
    logic [LAT_W-1:0] lat_m1;

    // A fixed producer with rem==0 is writing back now; with a bypass the consumer can take it.
    assign raw1 = dec_valid_i & dec_rs1_needed_i & (dec_rs1_i != '0) & busy_q[dec_rs1_i]
                & ~(FwdEn & ~var_q[dec_rs1_i] & (rem_q[dec_rs1_i] == '0));
    assign raw2 = dec_valid_i & dec_rs2_needed_i & (dec_rs2_i != '0) & busy_q[dec_rs2_i]
                & ~(FwdEn & ~var_q[dec_rs2_i] & (rem_q[dec_rs2_i] == '0));
    assign raw_any = raw1 | raw2;

    assign waw = dec_valid_i & dec_rd_wr_en_i & (dec_rd_i != '0) & busy_q[dec_rd_i];

    genvar gi;
    generate
        for (gi = 0; gi <= MAX_LAT; gi++) begin : g_lat_hit
            assign lat_hit[gi] = (dec_latency_i == LAT_W'(gi));
        end
    endgenerate

    assign wb_conflict = dec_valid_i & dec_rd_wr_en_i & (dec_latency_i != '0)
                       & (|(wheel_q & lat_hit));

    assign stall = dec_valid_i & (rob_is_full_i | ex_backpressure_i | raw_any | waw | wb_conflict);
    assign issue = dec_valid_i & ~stall & ~flush_i;

    assign alloc       = issue & dec_rd_wr_en_i & (dec_rd_i != '0);
    assign alloc_fixed = alloc & (dec_latency_i != '0);
    assign alloc_var   = alloc & (dec_latency_i == '0);
    assign lat_m1      = dec_latency_i - LAT_W'(1);

    // Fixed writebacks own the port; a colliding variable writeback retries next cycle.
    assign var_wb_deny  = var_wb_req_i & wheel_q[0];
    assign var_wb_grant = var_wb_req_i & ~wheel_q[0];

    generate
        for (gi = 0; gi <= MAX_LAT; gi++) begin : g_wheel
            if (gi < MAX_LAT) begin : g_shift
                assign wheel_d[gi] = wheel_q[gi+1]
                                   | (alloc_fixed & (dec_latency_i == LAT_W'(gi + 1)));
            end else begin : g_top
                assign wheel_d[gi] = 1'b0;
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic set_fix, set_var, fix_done, var_done, counting;

            assign set_fix  = alloc_fixed & (dec_rd_i == REGISTER_WIDTH'(gi));
            assign set_var  = alloc_var & (dec_rd_i == REGISTER_WIDTH'(gi));
            assign fix_done = busy_q[gi] & ~var_q[gi] & (rem_q[gi] == '0);
            assign var_done = busy_q[gi] & var_q[gi] & var_wb_grant
                            & (var_wb_reg_i == REGISTER_WIDTH'(gi));
            assign counting = busy_q[gi] & ~var_q[gi] & (rem_q[gi] != '0);

            // A new allocation overrides any completion on the same register.
            assign busy_d[gi] = set_fix | set_var | (busy_q[gi] & ~fix_done & ~var_done);
            assign var_d[gi]  = set_var | (~set_fix & busy_q[gi] & var_q[gi] & ~var_done);
            assign rem_d[gi]  = set_fix  ? lat_m1 :
                                set_var  ? '0 :
                                counting ? rem_q[gi] - LAT_W'(1) : rem_q[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            var_q   <= '0;
            wheel_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                rem_q[r] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            var_q   <= var_d;
            wheel_q <= wheel_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                rem_q[r] <= rem_d[r];
            end
        end
    end

    // Outputs are forced low while reset is asserted, even with a valid decode slot.
    assign issue_o        = rst_ni & issue;
    assign stall_decode_o = rst_ni & stall;
    assign stall_fetch_o  = rst_ni & stall;
    assign raw_stall_o    = rst_ni & raw_any;
    assign waw_stall_o    = rst_ni & waw;
    assign wb_conflict_o  = rst_ni & wb_conflict;
    assign var_wb_stall_o = rst_ni & var_wb_deny;
    assign busy_regs_o    = busy_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     dec_valid_i |-> (dec_latency_i <= LAT_W'(MAX_LAT)));

endmodule
